// File: rtl/axis_player_pkg.sv
// Shared types and constants for the AXI-Stream flit player and its
// optional tvalid throttle (enabled by defining AXIS_PLAYER_THROTTLE_EN).
package axis_player_pkg;

  localparam int FLIT_DATA_W = 64;
  localparam int FLIT_KEEP_W = FLIT_DATA_W / 8;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic [FLIT_KEEP_W-1:0] keep;
    logic                   last;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/axis_player_lfsr.sv
// 16-bit Fibonacci LFSR used to pace new-beat offers when
// AXIS_PLAYER_THROTTLE_EN is defined; exposes only the newest bit.
module axis_player_lfsr
  import axis_player_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  output logic bit_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
  assign bit_o  = lfsr_q[0];

  // Free-running shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/axis_flit_player.sv
// AXI-Stream packet source: flits are loaded into a buffer and replayed with gap,
// loop and stop control. Define AXIS_PLAYER_THROTTLE_EN for LFSR-paced tvalid.
module axis_flit_player
  import axis_player_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 1472,
  parameter  int GAP_W  = 8,
  parameter  int CNT_W  = 32,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              ARESETN,
  input  logic              ld_en,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [KEEP_W-1:0] ld_keep,
  input  logic              ld_last,
  input  logic              ld_clear,
  output logic              ld_full,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [GAP_W-1:0]  ipg_cycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [DATA_W-1:0] M_AXIS_tdata,
  output logic [KEEP_W-1:0] M_AXIS_tkeep,
  output logic              M_AXIS_tlast,
  output logic              M_AXIS_tvalid,
  input  logic              M_AXIS_tready
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = $clog2(DEPTH + 1);
  localparam int FLIT_W = DATA_W + KEEP_W + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  ipg_q, ipg_d;
  logic              loop_q, loop_d;
  logic              stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q;
  logic [KEEP_W-1:0] tkeep_q;
  logic              tlast_q;

  logic              we_s;
  logic              fetch_s;
  logic [PW-1:0]     fetch_addr_s;
  logic [PW-1:0]     rd_hold_s;
  logic              offer_s;
  logic              accept_s;
  logic              end_buf_s;
  logic              finish_s;
  logic [PW-1:0]     cont_addr_s;

`ifdef AXIS_PLAYER_THROTTLE_EN
  logic lfsr_bit_s;

  axis_player_lfsr u_lfsr (
    .clk_i  (CLK),
    .rst_ni (ARESETN),
    .bit_o  (lfsr_bit_s)
  );

  assign offer_s = lfsr_bit_s;
`else
  assign offer_s = 1'b1;
`endif

  // rd_ptr always points one past the entry currently held in the output stage.
  assign accept_s    = tvalid_q & M_AXIS_tready;
  assign end_buf_s   = (rd_ptr_q == wr_ptr_q);
  assign finish_s    = stop_pend_q | stop | (end_buf_s & ~loop_q);
  assign cont_addr_s = end_buf_s ? '0 : rd_ptr_q;

  // Next-state logic for the replay FSM, loader and counters.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_hold_s    = rd_ptr_q;
    gap_d        = gap_q;
    ipg_d        = ipg_q;
    loop_d       = loop_q;
    stop_pend_d  = stop_pend_q;
    beat_d       = beat_q;
    pkt_d        = pkt_q;
    we_s         = 1'b0;
    fetch_s      = 1'b0;
    fetch_addr_s = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_clear) begin
          wr_ptr_d = '0;
        end else if (ld_en && !full_q) begin
          we_s     = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        if (start) begin
          beat_d      = '0;
          pkt_d       = '0;
          loop_d      = loop;
          ipg_d       = ipg_cycles;
          stop_pend_d = stop;
          if (wr_ptr_q != '0) begin
            state_d      = ST_PLAY;
            rd_hold_s    = '0;
            fetch_addr_s = '0;
            fetch_s      = offer_s;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        stop_pend_d = stop_pend_q | stop;
        if (accept_s) begin
          beat_d = beat_q + CNT_W'(1);
          pkt_d  = tlast_q ? (pkt_q + CNT_W'(1)) : pkt_q;
          // A buffer end without tlast closes the packet just like tlast does.
          if (tlast_q || end_buf_s) begin
            if (ipg_q != '0) begin
              state_d = ST_GAP;
              gap_d   = ipg_q - GAP_W'(1);
            end else if (finish_s) begin
              state_d = ST_DONE;
            end else begin
              state_d      = ST_PLAY;
              rd_hold_s    = cont_addr_s;
              fetch_addr_s = cont_addr_s;
              fetch_s      = offer_s;
            end
          end else begin
            fetch_s = offer_s;
          end
        end else if (!tvalid_q) begin
          fetch_s = offer_s;
        end else begin
          fetch_s = 1'b0;
        end
      end
      ST_GAP: begin
        stop_pend_d = stop_pend_q | stop;
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (finish_s) begin
          state_d = ST_DONE;
        end else begin
          state_d      = ST_PLAY;
          rd_hold_s    = cont_addr_s;
          fetch_addr_s = cont_addr_s;
          fetch_s      = offer_s;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        stop_pend_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rd_ptr_d = fetch_s ? (fetch_addr_s + PW'(1)) : rd_hold_s;
    tvalid_d = fetch_s | (tvalid_q & ~accept_s);
    full_d   = (wr_ptr_d == DEPTH_P);
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
  end

  // Control and status registers.
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      gap_q       <= '0;
      ipg_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      beat_q      <= '0;
      pkt_q       <= '0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gap_q       <= gap_d;
      ipg_q       <= ipg_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      beat_q      <= beat_d;
      pkt_q       <= pkt_d;
      full_q      <= full_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tvalid_q    <= tvalid_d;
    end
  end

  // Flit buffer write port; contents survive reset but become unreachable.
  always_ff @(posedge CLK) begin
    if (we_s) begin
      mem[wr_ptr_q[AW-1:0]] <= {ld_last, ld_keep, ld_data};
    end
  end

  // Output stage doubles as the buffer's registered read port; holds while stalled.
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
    end else if (fetch_s) begin
      {tlast_q, tkeep_q, tdata_q} <= mem[fetch_addr_s[AW-1:0]];
    end else begin
      tdata_q <= tdata_q;
      tkeep_q <= tkeep_q;
      tlast_q <= tlast_q;
    end
  end

  assign ld_full       = full_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_count    = beat_q;
  assign pkt_count     = pkt_q;
  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tkeep  = tkeep_q;
  assign M_AXIS_tlast  = tlast_q;
  assign M_AXIS_tvalid = tvalid_q;

endmodule
